// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer and the conv unit controller.
// The state encodings live here so both sides decode current_state identically.
package conv_layer_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_INIT = 3'b000;
    localparam logic [STATE_W-1:0] ST_A    = 3'b001;
    localparam logic [STATE_W-1:0] ST_B    = 3'b010;
    localparam logic [STATE_W-1:0] ST_C    = 3'b011;

endpackage

// File: rtl/layer_tile_counter.sv
// Per-layer output tile counter: loads on layer entry, counts tile_done strobes,
// and flags when the selected layer count has been reached.
module layer_tile_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_cnt,
    input  logic         i_inc,
    input  logic [W-1:0] i_cmp_cnt,
    output logic [W-1:0] o_tile_idx,
    output logic         o_reached,
    output logic         o_last_c
);

    logic [W-1:0] r_idx;
    logic         r_reached;
    logic [W-1:0] w_idx_inc;

    // Increments are only issued while r_idx < i_cmp_cnt, so r_idx + 1 never wraps.
    assign w_idx_inc = r_idx + W'(1);
    assign o_last_c  = (w_idx_inc == i_cmp_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx     <= '0;
            r_reached <= 1'b0;
        end else if (i_clr) begin
            r_idx     <= '0;
            r_reached <= 1'b0;
        end else if (i_load) begin
            r_idx     <= '0;
            r_reached <= (i_load_cnt == '0);
        end else if (i_inc) begin
            r_idx     <= w_idx_inc;
            r_reached <= o_last_c;
        end
    end

    assign o_tile_idx = r_idx;
    assign o_reached  = r_reached;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer: drives current_state INIT -> A -> B -> C -> INIT for one inference
// pass, counting output tiles per layer and advancing on the controller's state_rst.
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int unsigned TILE_CNT_WIDTH = 16,
    parameter int unsigned STATE_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_a,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_b,
    input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_c,
    input  logic                      tile_done,
    input  logic                      state_rst,
    output logic [STATE_WIDTH-1:0]    current_state,
    output logic                      layer_start,
    output logic [TILE_CNT_WIDTH-1:0] tile_idx,
    output logic                      draining,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    logic [STATE_W-1:0]        r_state;
    logic [TILE_CNT_WIDTH-1:0] r_cfg_a;
    logic [TILE_CNT_WIDTH-1:0] r_cfg_b;
    logic [TILE_CNT_WIDTH-1:0] r_cfg_c;
    logic                      r_layer_start;
    logic                      r_done;
    logic                      r_err;
    logic                      r_busy;

    logic [STATE_W-1:0]        w_state_nxt;
    logic                      w_layer_start_nxt;
    logic                      w_done_nxt;
    logic                      w_err_nxt;
    logic [TILE_CNT_WIDTH-1:0] w_cmp_cnt;
    logic [TILE_CNT_WIDTH-1:0] w_load_cnt;
    logic                      w_in_layer;
    logic                      w_start_ok;
    logic                      w_tile_ok;
    logic                      w_final;
    logic                      w_adv;
    logic                      w_err_set;
    logic [TILE_CNT_WIDTH-1:0] w_tile_idx;
    logic                      w_reached;
    logic                      w_last;

    // Count of the layer in progress, and of the layer about to be entered.
    always_comb begin
        w_cmp_cnt  = r_cfg_a;
        w_load_cnt = cfg_tiles_a;
        case (r_state)
            ST_A: begin
                w_cmp_cnt  = r_cfg_a;
                w_load_cnt = r_cfg_b;
            end
            ST_B: begin
                w_cmp_cnt  = r_cfg_b;
                w_load_cnt = r_cfg_c;
            end
            ST_C: begin
                w_cmp_cnt  = r_cfg_c;
                w_load_cnt = '0;
            end
            default: begin
                w_cmp_cnt  = r_cfg_a;
                w_load_cnt = cfg_tiles_a;
            end
        endcase
    end

    assign w_in_layer = (r_state == ST_A) || (r_state == ST_B) || (r_state == ST_C);
    assign w_start_ok = (r_state == ST_INIT) && start;
    assign w_tile_ok  = w_in_layer && tile_done && !w_reached;
    // A final tile arriving with state_rst lets the layer advance in the same cycle.
    assign w_final    = w_tile_ok && w_last;
    assign w_adv      = w_in_layer && state_rst && (w_reached || w_final);
    assign w_err_set  = (state_rst && !w_adv) || (tile_done && !w_tile_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_layer_start_nxt = 1'b0;
        w_done_nxt        = 1'b0;
        w_err_nxt         = r_err;
        case (r_state)
            ST_INIT: begin
                if (start) begin
                    w_state_nxt       = ST_A;
                    w_layer_start_nxt = 1'b1;
                end
            end
            ST_A: begin
                if (w_adv) begin
                    w_state_nxt       = ST_B;
                    w_layer_start_nxt = 1'b1;
                end
            end
            ST_B: begin
                if (w_adv) begin
                    w_state_nxt       = ST_C;
                    w_layer_start_nxt = 1'b1;
                end
            end
            ST_C: begin
                if (w_adv) begin
                    w_state_nxt = ST_INIT;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (w_start_ok) begin
            w_err_nxt = 1'b0;
        end
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end
    end

    // Config latches are sampled only when a start is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_a       <= '0;
            r_cfg_b       <= '0;
            r_cfg_c       <= '0;
            r_layer_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cfg_a <= cfg_tiles_a;
                r_cfg_b <= cfg_tiles_b;
                r_cfg_c <= cfg_tiles_c;
            end
            r_layer_start <= w_layer_start_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= (w_state_nxt != ST_INIT);
        end
    end

    layer_tile_counter #(
        .W (TILE_CNT_WIDTH)
    ) u_tile_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_done_nxt),
        .i_load     (w_layer_start_nxt),
        .i_load_cnt (w_load_cnt),
        .i_inc      (w_tile_ok),
        .i_cmp_cnt  (w_cmp_cnt),
        .o_tile_idx (w_tile_idx),
        .o_reached  (w_reached),
        .o_last_c   (w_last)
    );

    assign current_state = STATE_WIDTH'(r_state);
    assign layer_start   = r_layer_start;
    assign tile_idx      = w_tile_idx;
    assign draining      = w_reached;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule
